// File: rtl/tinyalu_arbiter_if.sv
// ---------------------------------------------------------------------------
// tinyalu_arbiter_if
//   Bundle of the request, response and ALU-side signals of tinyalu_arbiter.
//   Signal names keep the direction suffix as seen from the arbiter.
//
//   Parameters : NUM_REQ (requester count), ID_W (response id width)
//   Requests   : req_valid_i / req_ready_o per requester, op/A/B packed
//                per requester (op at [3i+2:3i], A/B at [8i+7:8i])
//   Response   : rsp_valid_o / rsp_ready_i, rsp_id_o, rsp_result_o, rsp_err_o
//   ALU        : alu_start_o, alu_op_o, alu_a_o, alu_b_o, alu_done_i,
//                alu_result_i
//   Modports   : slave  - the arbiter
//                master - requesters plus the ALU (bench / BFM side)
// ---------------------------------------------------------------------------
interface tinyalu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [3*NUM_REQ-1:0] req_op_i;
  logic [8*NUM_REQ-1:0] req_a_i;
  logic [8*NUM_REQ-1:0] req_b_i;

  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [ID_W-1:0]      rsp_id_o;
  logic [15:0]          rsp_result_o;
  logic                 rsp_err_o;

  logic                 alu_start_o;
  logic [2:0]           alu_op_o;
  logic [7:0]           alu_a_o;
  logic [7:0]           alu_b_o;
  logic                 alu_done_i;
  logic [15:0]          alu_result_i;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i,
    input  rsp_ready_i, alu_done_i, alu_result_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_err_o,
    output alu_start_o, alu_op_o, alu_a_o, alu_b_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i,
    output rsp_ready_i, alu_done_i, alu_result_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_err_o,
    input  alu_start_o, alu_op_o, alu_a_o, alu_b_o
  );
endinterface

// File: rtl/tinyalu_arbiter.sv
// ---------------------------------------------------------------------------
// tinyalu_arbiter
//   Round-robin scheduler sharing one tinyalu between NUM_REQ requesters.
//   A request {op, A, B} is granted in IDLE, run on the ALU in BUSY and
//   returned tagged with the requester index in RESP.
//
//   Parameters : NUM_REQ (2..16), ID_W, TIMEOUT (BUSY cycle limit)
//   Ports      : clk_i    - clock, posedge
//                reset_i  - asynchronous active-high reset
//                bus      - tinyalu_arbiter_if.slave (requests, response,
//                           ALU start/operands/done/result)
//
//   Build option: TINYALU_ARB_TIMEOUT_EN - when defined, BUSY gives up after
//   TIMEOUT cycles without alu_done_i and answers result=16'hFFFF, err=1.
//   When undefined BUSY waits for alu_done_i indefinitely.
// ---------------------------------------------------------------------------
module tinyalu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = 15
) (
  input  logic             clk_i,
  input  logic             reset_i,
  tinyalu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] id_q;
  logic [2:0]      op_q;
  logic [7:0]      a_q;
  logic [7:0]      b_q;
  logic [15:0]     result_q;
  logic            err_q;
  logic            alu_start_q;
  logic            rsp_valid_q;

  logic               gnt_vld;
  logic [ID_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] req_ready;
  logic [2:0]         gnt_op;
  logic [7:0]         gnt_a;
  logic [7:0]         gnt_b;
  logic [ID_W-1:0]    ptr_d;

`ifdef TINYALU_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CNT_W-1:0] cnt_q;
`endif

  function automatic logic op_legal(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  // Round-robin search: walk offsets from the highest down so that the
  // lowest offset from the pointer is the one left standing.
  // The grant is suppressed while reset is asserted so every output is 0.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (state_q == IDLE && !reset_i) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (bus.req_valid_i[(int'(ptr_q) + k) % NUM_REQ]) begin
          gnt_vld = 1'b1;
          gnt_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  assign gnt_op = bus.req_op_i[3*gnt_idx +: 3];
  assign gnt_a  = bus.req_a_i[8*gnt_idx +: 8];
  assign gnt_b  = bus.req_b_i[8*gnt_idx +: 8];
  assign ptr_d  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      alu_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef TINYALU_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            ptr_q <= ptr_d;
            id_q  <= gnt_idx;
            op_q  <= gnt_op;
            a_q   <= gnt_a;
            b_q   <= gnt_b;
            if (op_legal(gnt_op)) begin
              state_q     <= BUSY;
              alu_start_q <= 1'b1;
`ifdef TINYALU_ARB_TIMEOUT_EN
              cnt_q       <= '0;
`endif
            end else begin
              // Illegal op: answer straight away, the ALU is never started.
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              result_q    <= 16'h0000;
              err_q       <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (bus.alu_done_i) begin
            state_q     <= RESP;
            alu_start_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            result_q    <= bus.alu_result_i;
            err_q       <= 1'b0;
          end
`ifdef TINYALU_ARB_TIMEOUT_EN
          // cnt_q counts completed BUSY cycles; the last allowed cycle is
          // TIMEOUT-1, so RESP is reached exactly TIMEOUT cycles after entry.
          else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q     <= RESP;
            alu_start_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            result_q    <= 16'hFFFF;
            err_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_id_o     = id_q;
  assign bus.rsp_result_o = result_q;
  assign bus.rsp_err_o    = err_q;
  assign bus.alu_start_o  = alu_start_q;
  assign bus.alu_op_o     = op_q;
  assign bus.alu_a_o      = a_q;
  assign bus.alu_b_o      = b_q;

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tinyalu_arbiter
//   Bench for tinyalu_arbiter: requesters and a behavioural tinyalu with
//   random latency, plus a round-robin/result reference model.
// ---------------------------------------------------------------------------
module tb_tinyalu_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TMO = 15;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  tinyalu_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();

  tinyalu_arbiter #(.NUM_REQ(N), .ID_W(IDW), .TIMEOUT(TMO)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int          n_vec;
  int          n_err;
  int          ptr_m;
  bit          keep [N];
  bit          alu_en;
  int          alu_cnt;
  int          alu_lat;
  bit          start_seen;
  int          last_id;
  logic [15:0] last_res;
  logic        last_err;

  // Reference: what tinyalu computes for a legal op.
  function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    case (op)
      3'd1: return 16'(a) + 16'(b);
      3'd2: return {8'h00, a & b};
      3'd3: return {8'h00, a ^ b};
      3'd4: return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  // Reference: first valid requester at or after the pointer, wrapping.
  function automatic int rr_pick(input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Behavioural ALU: done pulses alu_lat cycles after start is seen.
  // The result bus carries noise whenever done is low.
  always @(negedge clk_i) begin
    if (bus.alu_done_i) begin
      bus.alu_done_i   = 1'b0;
      bus.alu_result_i = 16'($urandom);
      alu_cnt          = 0;
      alu_lat          = $urandom_range(0, 3);
    end else if (alu_en && bus.alu_start_o === 1'b1 && !reset_i) begin
      if (alu_cnt >= alu_lat) begin
        bus.alu_done_i   = 1'b1;
        bus.alu_result_i = alu_ref(bus.alu_op_o, bus.alu_a_o, bus.alu_b_o);
      end else begin
        alu_cnt++;
      end
    end else begin
      alu_cnt          = 0;
      bus.alu_result_i = 16'($urandom);
    end
  end

  always @(posedge clk_i)
    if (bus.alu_start_o === 1'b1) start_seen = 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b);
    bus.req_op_i[3*i +: 3] = op;
    bus.req_a_i[8*i +: 8]  = a;
    bus.req_b_i[8*i +: 8]  = b;
    bus.req_valid_i[i]     = 1'b1;
  endtask

  task automatic new_req(input int i, input bit legal_only);
    logic [2:0] op;
    op = legal_only ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7));
    set_req(i, op, 8'($urandom), 8'($urandom));
  endtask

  // One full transaction: grant, ALU phase, response with bp cycles of
  // backpressure, response handshake.
  task automatic do_txn(input int bp);
    int          exp_id;
    int          k;
    logic [N-1:0] exp_rdy;
    logic [2:0]  op;
    logic [7:0]  a, b;
    logic        legal;
    logic [15:0] exp_res;
    logic        exp_err;
    logic [IDW+16:0] snap;
    #1;
    k = 0;
    while (bus.req_ready_o == '0 && k < 50) begin
      @(negedge clk_i); #1; k++;
    end
    n_vec++;
    if (bus.req_ready_o == '0) begin
      n_err++;
      $display("FAIL grant_wait: req_ready_o stayed 0, expected a grant");
      return;
    end
    exp_id  = rr_pick(ptr_m, bus.req_valid_i);
    exp_rdy = '0;
    if (exp_id >= 0) exp_rdy[exp_id] = 1'b1;
    n_vec++;
    if (bus.req_ready_o !== exp_rdy) begin
      n_err++;
      $display("FAIL grant: req_ready_o=%b expected %b", bus.req_ready_o, exp_rdy);
    end
    if (exp_id < 0) exp_id = 0;
    op      = bus.req_op_i[3*exp_id +: 3];
    a       = bus.req_a_i[8*exp_id +: 8];
    b       = bus.req_b_i[8*exp_id +: 8];
    legal   = (op >= 3'd1) && (op <= 3'd4);
    exp_res = legal ? alu_ref(op, a, b) : 16'h0000;
    exp_err = !legal;

    @(negedge clk_i);
    n_vec++;
    if (legal) begin
      if ({bus.alu_start_o, bus.alu_op_o, bus.alu_a_o, bus.alu_b_o} !== {1'b1, op, a, b}) begin
        n_err++;
        $display("FAIL alu_start_t1: start/op/a/b=%b/%0d/%h/%h expected 1/%0d/%h/%h",
                 bus.alu_start_o, bus.alu_op_o, bus.alu_a_o, bus.alu_b_o, op, a, b);
      end
    end else begin
      if ({bus.rsp_valid_o, bus.alu_start_o} !== 2'b10) begin
        n_err++;
        $display("FAIL illegal_t1: rsp_valid/alu_start=%b%b expected 10",
                 bus.rsp_valid_o, bus.alu_start_o);
      end
    end
    if (keep[exp_id]) new_req(exp_id, 1'b0);
    else bus.req_valid_i[exp_id] = 1'b0;
    ptr_m = (exp_id + 1) % N;

    k = 0;
    while (bus.rsp_valid_o !== 1'b1 && k < 100) begin
      n_vec++;
      if ({bus.alu_start_o, bus.alu_op_o, bus.alu_a_o, bus.alu_b_o} !== {1'b1, op, a, b}) begin
        n_err++;
        $display("FAIL alu_hold: start/op/a/b=%b/%0d/%h/%h expected 1/%0d/%h/%h",
                 bus.alu_start_o, bus.alu_op_o, bus.alu_a_o, bus.alu_b_o, op, a, b);
      end
      @(negedge clk_i); k++;
    end
    n_vec++;
    if (bus.rsp_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL rsp_wait: rsp_valid_o=%b expected 1", bus.rsp_valid_o);
      return;
    end
    n_vec++;
    if (bus.alu_start_o !== 1'b0) begin
      n_err++;
      $display("FAIL alu_start_drop: alu_start_o=%b expected 0", bus.alu_start_o);
    end
    n_vec++;
    if ({bus.rsp_id_o, bus.rsp_result_o, bus.rsp_err_o} !== {IDW'(exp_id), exp_res, exp_err}) begin
      n_err++;
      $display("FAIL rsp_fields: id/result/err=%0d/%h/%b expected %0d/%h/%b",
               bus.rsp_id_o, bus.rsp_result_o, bus.rsp_err_o, exp_id, exp_res, exp_err);
    end
    last_id  = int'(bus.rsp_id_o);
    last_res = bus.rsp_result_o;
    last_err = bus.rsp_err_o;
    snap     = {bus.rsp_id_o, bus.rsp_result_o, bus.rsp_err_o};

    repeat (bp) begin
      @(negedge clk_i);
      n_vec++;
      if ({bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_result_o, bus.rsp_err_o, bus.req_ready_o}
          !== {1'b1, snap, {N{1'b0}}}) begin
        n_err++;
        $display("FAIL backpressure: valid/id/res/err/ready=%b/%0d/%h/%b/%b expected 1/%0d/%h/%b/0",
                 bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_result_o, bus.rsp_err_o,
                 bus.req_ready_o, exp_id, exp_res, exp_err);
      end
    end
    bus.rsp_ready_i = 1'b1;
    #1;
    n_vec++;
    if (bus.req_ready_o !== '0) begin
      n_err++;
      $display("FAIL no_grant_in_rsp: req_ready_o=%b expected 0", bus.req_ready_o);
    end
    @(negedge clk_i);
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic drain();
    int g;
    for (int i = 0; i < N; i++) keep[i] = 1'b0;
    g = 0;
    while (bus.req_valid_i != '0 && g < 20) begin
      do_txn(0);
      g++;
    end
  endtask

  task automatic hard_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    ptr_m   = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    set_req(0, 3'd1, 8'h01, 8'h02);
    #1;
    n_vec++;
    if ({bus.req_ready_o, bus.rsp_valid_o, bus.alu_start_o} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: ready/rsp_valid/start=%b/%b/%b expected 0/0/0",
               bus.req_ready_o, bus.rsp_valid_o, bus.alu_start_o);
    end
    n_vec++;
    if ({bus.rsp_id_o, bus.rsp_result_o, bus.rsp_err_o} !== '0) begin
      n_err++;
      $display("FAIL reset_rsp: id/result/err=%0d/%h/%b expected 0/0000/0",
               bus.rsp_id_o, bus.rsp_result_o, bus.rsp_err_o);
    end
    n_vec++;
    if ({bus.alu_op_o, bus.alu_a_o, bus.alu_b_o} !== '0) begin
      n_err++;
      $display("FAIL reset_alu: op/a/b=%0d/%h/%h expected 0/00/00",
               bus.alu_op_o, bus.alu_a_o, bus.alu_b_o);
    end
    bus.req_valid_i = '0;
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if ({bus.req_ready_o, bus.rsp_valid_o, bus.alu_start_o} !== '0) begin
      n_err++;
      $display("FAIL idle_after_reset: ready/rsp_valid/start=%b/%b/%b expected 0/0/0",
               bus.req_ready_o, bus.rsp_valid_o, bus.alu_start_o);
    end
  endtask

  task automatic test_single_add();
    set_req(0, 3'd1, 8'h12, 8'h34);
    do_txn(0);
    n_vec++;
    if ({last_id, last_res, last_err} !== {32'd0, 16'h0046, 1'b0}) begin
      n_err++;
      $display("FAIL single_add: id/result/err=%0d/%h/%b expected 0/0046/0", last_id, last_res, last_err);
    end
  endtask

  task automatic test_multiply();
    alu_lat = 3;
    set_req(2, 3'd4, 8'hFF, 8'hFF);
    do_txn(0);
    n_vec++;
    if ({last_id, last_res, last_err} !== {32'd2, 16'hFE01, 1'b0}) begin
      n_err++;
      $display("FAIL multiply: id/result/err=%0d/%h/%b expected 2/fe01/0", last_id, last_res, last_err);
    end
  endtask

  task automatic test_fairness();
    hard_reset();
    for (int i = 0; i < N; i++) begin
      keep[i] = 1'b1;
      new_req(i, 1'b1);
    end
    for (int t = 0; t < 8; t++) begin
      do_txn(0);
      n_vec++;
      if (last_id !== t % N) begin
        n_err++;
        $display("FAIL fairness_order: txn %0d id=%0d expected %0d", t, last_id, t % N);
      end
    end
    drain();
  endtask

  task automatic test_illegal();
    start_seen = 1'b0;
    set_req(1, 3'd0, 8'h55, 8'h66);
    do_txn(0);
    n_vec++;
    if ({last_id, last_res, last_err} !== {32'd1, 16'h0000, 1'b1}) begin
      n_err++;
      $display("FAIL illegal_op0: id/result/err=%0d/%h/%b expected 1/0000/1", last_id, last_res, last_err);
    end
    set_req(3, 3'd7, 8'h77, 8'h88);
    do_txn(0);
    n_vec++;
    if ({last_id, last_res, last_err} !== {32'd3, 16'h0000, 1'b1}) begin
      n_err++;
      $display("FAIL illegal_op7: id/result/err=%0d/%h/%b expected 3/0000/1", last_id, last_res, last_err);
    end
    n_vec++;
    if (start_seen !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_no_start: alu_start_o seen=%b expected 0", start_seen);
    end
  endtask

  task automatic test_backpressure();
    set_req(0, 3'd3, 8'hA5, 8'h5A);
    set_req(2, 3'd2, 8'hF0, 8'h3C);
    do_txn(5);
    drain();
  endtask

  task automatic test_random();
    bit any;
    repeat (24) begin
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid_i[i] && $urandom_range(0, 1) == 1) new_req(i, 1'b0);
        keep[i] = ($urandom_range(0, 2) == 0);
        if (bus.req_valid_i[i]) any = 1'b1;
      end
      if (!any) new_req($urandom_range(0, N - 1), 1'b0);
      do_txn($urandom_range(0, 3));
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int k;
    alu_en = 1'b0;
    set_req(2, 3'd1, 8'h10, 8'h20);
    #1;
    k = 0;
    while (bus.req_ready_o == '0 && k < 20) begin
      @(negedge clk_i); #1; k++;
    end
    @(negedge clk_i);
    n_vec++;
    if (bus.alu_start_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_busy: alu_start_o=%b expected 1", bus.alu_start_o);
    end
    #2;
    reset_i = 1'b1;
    #1;
    n_vec++;
    if ({bus.alu_start_o, bus.rsp_valid_o, bus.req_ready_o, bus.alu_op_o, bus.alu_a_o,
         bus.alu_b_o, bus.rsp_result_o, bus.rsp_err_o, bus.rsp_id_o} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: start/rsp_valid/ready/op=%b/%b/%b/%0d expected all 0",
               bus.alu_start_o, bus.rsp_valid_o, bus.req_ready_o, bus.alu_op_o);
    end
    set_req(0, 3'd3, 8'h0F, 8'hF0);
    set_req(1, 3'd2, 8'hCC, 8'hAA);
    @(negedge clk_i);
    reset_i = 1'b0;
    ptr_m   = 0;
    alu_en  = 1'b1;
    do_txn(0);
    n_vec++;
    if (last_id !== 0) begin
      n_err++;
      $display("FAIL reset_mid_regrant: id=%0d expected 0", last_id);
    end
    drain();
  endtask

`ifdef TINYALU_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    alu_en = 1'b0;
    set_req(1, 3'd4, 8'h03, 8'h04);
    #1;
    k = 0;
    while (bus.req_ready_o == '0 && k < 20) begin
      @(negedge clk_i); #1; k++;
    end
    bus.req_valid_i[1] = 1'b0;
    ptr_m = 2;
    @(negedge clk_i);
    k = 1;
    while (bus.rsp_valid_o !== 1'b1 && k < 100) begin
      @(negedge clk_i); k++;
    end
    n_vec++;
    if (k !== TMO + 1) begin
      n_err++;
      $display("FAIL timeout_latency: rsp_valid after %0d cycles expected %0d", k, TMO + 1);
    end
    n_vec++;
    if ({bus.rsp_id_o, bus.rsp_result_o, bus.rsp_err_o, bus.alu_start_o} !== {2'd1, 16'hFFFF, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL timeout_rsp: id/result/err/start=%0d/%h/%b/%b expected 1/ffff/1/0",
               bus.rsp_id_o, bus.rsp_result_o, bus.rsp_err_o, bus.alu_start_o);
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk_i);
    bus.rsp_ready_i = 1'b0;
    alu_en = 1'b1;
  endtask
`endif

  initial begin
    n_vec            = 0;
    n_err            = 0;
    ptr_m            = 0;
    alu_en           = 1'b1;
    alu_cnt          = 0;
    alu_lat          = 1;
    start_seen       = 1'b0;
    last_id          = 0;
    last_res         = '0;
    last_err         = 1'b0;
    for (int i = 0; i < N; i++) keep[i] = 1'b0;
    reset_i          = 1'b1;
    bus.req_valid_i  = '0;
    bus.req_op_i     = '0;
    bus.req_a_i      = '0;
    bus.req_b_i      = '0;
    bus.rsp_ready_i  = 1'b0;
    bus.alu_done_i   = 1'b0;
    bus.alu_result_i = '0;

    test_reset();
    test_single_add();
    test_multiply();
    test_fairness();
    test_illegal();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef TINYALU_ARB_TIMEOUT_EN
    test_timeout();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tinyalu_arbiter.md
# tinyalu_arbiter

Round-robin scheduler that shares a single `tinyalu` instance between `NUM_REQ` independent requesters. Each requester submits `{op, A, B}` over a valid/ready handshake. The arbiter grants one request at a time and drives the ALU `start`/operand interface until `done`. It then returns the 16-bit result tagged with the requester index over a valid/ready response channel. It sits between the stimulus/BFM layer and `tinyalu`, replacing direct per-test driving of the ALU pins.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the response ID.
- `TIMEOUT`, default 15: maximum cycles spent in BUSY waiting for `alu_done_i`. Used only with `TINYALU_ARB_TIMEOUT_EN`.
- `clk_i`  in  1  clock; all logic on posedge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_ready_o`  out  NUM_REQ  per-requester accept; at most one bit high.
- `req_op_i`  in  3*NUM_REQ  op for requester i at `[3i+2:3i]`.
- `req_a_i`  in  8*NUM_REQ  operand A for requester i at `[8i+7:8i]`.
- `req_b_i`  in  8*NUM_REQ  operand B, same packing.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response accept.
- `rsp_id_o`  out  ID_W  index of the requester being answered.
- `rsp_result_o`  out  16  ALU result.
- `rsp_err_o`  out  1  illegal op or timeout.
- `alu_start_o`  out  1  to tinyalu `start`.
- `alu_op_o`  out  3  to tinyalu `op`.
- `alu_a_o`  out  8  to tinyalu `A`.
- `alu_b_o`  out  8  to tinyalu `B`.
- `alu_done_i`  in  1  from tinyalu `done`.
- `alu_result_i`  in  16  from tinyalu `result`.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **Reset state:** state=IDLE, round-robin pointer=0, all outputs 0.
- **IDLE**
  - If any `req_valid_i` is set, grant the first set bit searching from the pointer upward, with wrap-around.
  - The grant is combinational: `req_ready_o[g]`=1 for that cycle only.
  - On the handshake, capture op/A/B and ID=g, and set pointer to (g+1) mod NUM_REQ.
  - Legal ops are 1=add, 2=and, 3=xor, 4=mul. A legal op moves to BUSY.
  - Illegal ops 0, 5, 6, 7 move directly to RESP with result=16'h0000 and err=1. The ALU is never started for them.
- **BUSY**
  - `alu_start_o`=1 and `alu_op/a/b_o` are driven from the captured registers.
  - All four ALU outputs are held stable for the whole BUSY state.
  - On the cycle `alu_done_i`=1: capture `alu_result_i`, set err=0, go to RESP.
  - `alu_start_o` is registered, so it drops on the next cycle.
- **RESP**
  - `rsp_valid_o`=1, with ID, result and err held stable until `rsp_ready_i`=1.
  - After the handshake, return to IDLE. No grant is made in the handshake cycle.
- `req_ready_o` is all-zero outside IDLE.
- `alu_done_i` is ignored outside BUSY.
- Results are passed through unmodified as 16 bits; the arbiter performs no arithmetic.

## Timing
- Request handshake at cycle T → `alu_start_o`=1 from T+1.
- `alu_done_i` high at cycle D → `rsp_valid_o`=1 from D+1, `alu_start_o`=0 from D+1.
- Illegal op accepted at T → `rsp_valid_o`=1 at T+1.
- Response handshake at R → next grant possible at R+1, at the earliest.
- **Simultaneous requests:** resolved strictly by the round-robin pointer. A requester that keeps `req_valid_i` high waits at most NUM_REQ-1 transactions.
- **Reset mid-operation:** all state clears asynchronously and `alu_start_o` drops immediately. An in-flight transaction is lost without a response. Requesters holding valid are re-arbitrated from pointer 0.

## Configuration
- **`TINYALU_ARB_TIMEOUT_EN` defined:**
  - A BUSY cycle counter clears on entry to BUSY.
  - If TIMEOUT cycles elapse without `alu_done_i`, go to RESP with result=16'hFFFF and err=1, and drop `alu_start_o`.
  - A later stray `alu_done_i` is ignored.
- **Not defined:** no counter; BUSY waits for `alu_done_i` indefinitely.

## Test plan
- **Single add:** requester 0, op=1, A=8'h12, B=8'h34 → `alu_start_o` at T+1; response ID=0, result=16'h0046, err=0.
- **Multiply:** requester 2, op=4, A=B=8'hFF → result=16'hFE01, ID=2; `alu_start_o` held until done.
- **Fairness:** all 4 requesters valid continuously, 8 transactions → grant order 0,1,2,3,0,1,2,3 with correct per-ID results.
- **Illegal op:** op=0 then op=7 → `rsp_valid_o` at T+1, result=0, err=1; `alu_start_o` never asserted.
- **Backpressure:** `rsp_ready_i` low for 5 cycles → response fields stable and no new `req_ready_o` until the handshake.
- **Timeout and reset:** with the macro defined and the ALU done tied low → err=1, result=16'hFFFF exactly TIMEOUT cycles after BUSY entry. Separately, `reset_i` pulsed in BUSY → all outputs 0 immediately and next grant from requester 0.
